// File: rtl/count_wrap_tracker.sv
// count_wrap_tracker
// Watches the count output of an upstream N-bit down counter and checks
// that every sampled step is a decrement by one, modulo 2^WIDTH. It extends
// the count with a wrap counter into a wider elapsed-ticks value, flags
// illegal steps, and runs an IDLE/ACQUIRE/LOCKED/FAULT health state machine.
// All outputs are registered and update one clock after the qualifying sample.
module count_wrap_tracker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned EXT_W    = 4,
    parameter int unsigned LOCK_LEN = 3,
    parameter int unsigned ERR_W    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       count_in,
    input  logic                   count_valid,
    input  logic                   upstream_rst,
    input  logic                   clr_err,
    output logic                   locked,
    output logic                   wrap_pulse,
    output logic [EXT_W-1:0]       wrap_cnt,
    output logic [EXT_W+WIDTH-1:0] elapsed,
    output logic                   step_err,
    output logic [ERR_W-1:0]       err_cnt
);

    // Run counter must be able to hold LOCK_LEN itself.
    localparam int unsigned RUN_W = (LOCK_LEN < 1) ? 1 : $clog2(LOCK_LEN + 1);

    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_LEN);
    localparam logic [EXT_W-1:0] WRAP_ONE = EXT_W'(1);
    localparam logic [ERR_W-1:0] ERR_ONE  = ERR_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACQUIRE,
        LOCKED,
        FAULT
    } state_t;

    state_t           state, state_n;

    logic [WIDTH-1:0] prev, prev_n;
    logic [RUN_W-1:0] run, run_n;
    logic [EXT_W-1:0] wrap_cnt_n;
    logic             step_err_n;
    logic [ERR_W-1:0] err_cnt_n;
    logic             wrap_pulse_n;

    logic [WIDTH-1:0] prev_dec;
    logic             legal;
    logic             at_zero;
    logic [RUN_W-1:0] run_inc;
    logic             err_sat;

    // Step classification helpers derived from the last accepted sample.
    always_comb begin
        prev_dec = prev - CNT_ONE;
        legal    = (count_in == prev_dec);
        at_zero  = (prev == '0);
        run_inc  = run + RUN_ONE;
        err_sat  = (err_cnt == '1);
    end

    // Next-state and next-datapath decode; priority upstream_rst > clr_err > count_valid.
    always_comb begin
        state_n      = state;
        prev_n       = prev;
        run_n        = run;
        wrap_cnt_n   = wrap_cnt;
        step_err_n   = step_err;
        err_cnt_n    = err_cnt;
        wrap_pulse_n = 1'b0;

        if (upstream_rst) begin
            state_n    = IDLE;
            prev_n     = '1;
            run_n      = '0;
            wrap_cnt_n = '0;
            if (clr_err) begin
                step_err_n = 1'b0;
            end
        end else if (clr_err) begin
            step_err_n = 1'b0;
            if (state == FAULT) begin
                state_n = IDLE;
            end
        end else if (count_valid) begin
            unique case (state)
                IDLE: begin
                    prev_n  = count_in;
                    run_n   = '0;
                    state_n = ACQUIRE;
                end
                ACQUIRE: begin
                    prev_n = count_in;
                    if (legal) begin
                        run_n = run_inc;
                        if (run_inc == RUN_LOCK) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        run_n = '0;
                    end
                end
                LOCKED: begin
                    prev_n = count_in;
                    if (legal) begin
                        if (at_zero) begin
                            wrap_pulse_n = 1'b1;
                            wrap_cnt_n   = wrap_cnt + WRAP_ONE;
                        end
                    end else begin
                        step_err_n = 1'b1;
                        if (!err_sat) begin
                            err_cnt_n = err_cnt + ERR_ONE;
                        end
                        state_n = FAULT;
                    end
                end
                FAULT: begin
                    // Samples are ignored until clr_err or upstream_rst.
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Datapath and registered outputs; locked is decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev       <= '1;
            run        <= '0;
            locked     <= 1'b0;
            wrap_pulse <= 1'b0;
            wrap_cnt   <= '0;
            step_err   <= 1'b0;
            err_cnt    <= '0;
        end else begin
            prev       <= prev_n;
            run        <= run_n;
            locked     <= (state_n == LOCKED);
            wrap_pulse <= wrap_pulse_n;
            wrap_cnt   <= wrap_cnt_n;
            step_err   <= step_err_n;
            err_cnt    <= err_cnt_n;
        end
    end

    // Elapsed ticks since all-ones: wraps above, down-count distance below.
    always_comb begin
        elapsed = {wrap_cnt, ~prev};
    end

endmodule
